// File: rtl/dic_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : dic_tx_sched
//  Description : Shares the UART transmitter between the key echo (every rx
//                byte) and the once-per-second "MM:SSf\r\n" time report.
//                Echo has priority. A report frame is never interrupted.
//  Revision    : 1.0 - initial release
// ============================================================================
module dic_tx_sched #(
  parameter int ECHO_DEPTH = 4,
  parameter int FRAME_LEN  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data_rdy,
  input  logic [7:0] rx_data,
  input  logic       tick1s,
  input  logic       rpt_ena,
  input  logic       alarm_ena,
  input  logic [3:0] dMtens,
  input  logic [3:0] dMones,
  input  logic [3:0] dStens,
  input  logic [3:0] dSones,
  input  logic       tx_rdy,
  output logic [7:0] tx_data,
  output logic       tx_data_vld,
  output logic       echo_ovf,
  output logic       busy
);

  localparam int c_aw = $clog2(ECHO_DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam int c_iw = $clog2(FRAME_LEN);
  localparam logic [c_cw-1:0] c_full = c_cw'(ECHO_DEPTH);
  localparam logic [c_iw-1:0] c_last = c_iw'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ECHO  = 2'd1,
    S_FRAME = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        fifo_q [ECHO_DEPTH];
  logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              pend_q, pend_d;
  // Frame snapshot: {alarm, Mtens, Mones, Stens, Sones}
  logic [16:0]       snap_q, snap_d;
  logic [c_iw-1:0]   idx_q, idx_d;
  logic [7:0]        txd_q, txd_d;
  logic              vld_q, vld_d;

  logic              w_push;
  logic              w_pop;
  logic              w_start_frame;
  logic              w_xfer;
  logic              w_full;
  logic              w_empty;
  logic [16:0]       w_snap_now;

  // Byte of the report frame at position idx, built from a digit snapshot
  function automatic logic [7:0] frame_byte(input logic [c_iw-1:0] idx,
                                             input logic [16:0]     snap);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      c_iw'(0): b = {4'h3, snap[15:12]};
      c_iw'(1): b = {4'h3, snap[11:8]};
      c_iw'(2): b = 8'h3A;
      c_iw'(3): b = {4'h3, snap[7:4]};
      c_iw'(4): b = {4'h3, snap[3:0]};
      c_iw'(5): b = snap[16] ? 8'h41 : 8'h20;
      c_iw'(6): b = 8'h0D;
      c_iw'(7): b = 8'h0A;
      default:  b = 8'h00;
    endcase
    return b;
  endfunction

  assign w_full     = (cnt_q == c_full);
  assign w_empty    = (cnt_q == '0);
  assign w_xfer     = vld_q & tx_rdy;
  assign w_push     = rx_data_rdy & ~w_full;
  assign w_snap_now = {alarm_ena, dMtens, dMones, dStens, dSones};

  // Grant arbitration, handshake sequencing and FIFO/request bookkeeping
  always_comb begin
    state_d       = state_q;
    txd_d         = txd_q;
    vld_d         = vld_q;
    idx_d         = idx_q;
    snap_d        = snap_q;
    w_pop         = 1'b0;
    w_start_frame = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          txd_d   = fifo_q[rd_ptr_q];
          vld_d   = 1'b1;
          state_d = S_ECHO;
        end else if (pend_q) begin
          w_start_frame = 1'b1;
          snap_d        = w_snap_now;
          idx_d         = '0;
          txd_d         = frame_byte('0, w_snap_now);
          vld_d         = 1'b1;
          state_d       = S_FRAME;
        end
      end
      S_ECHO: begin
        if (w_xfer) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_FRAME: begin
        if (w_xfer) begin
          if (idx_q == c_last) begin
            vld_d   = 1'b0;
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + c_iw'(1);
            txd_d = frame_byte(idx_q + c_iw'(1), snap_q);
          end
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    wr_ptr_d = w_push ? wr_ptr_q + c_aw'(1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + c_aw'(1) : rd_ptr_q;
    cnt_d    = cnt_q + c_cw'(w_push) - c_cw'(w_pop);
    // Full is judged before any same-cycle pop, so that byte is lost
    ovf_d    = ovf_q | (rx_data_rdy & w_full);
    // A tick arriving while a request is being served folds into it
    if (w_start_frame) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q | (tick1s & rpt_ena);
    end
  end

  // State and datapath registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
      snap_q   <= '0;
      idx_q    <= '0;
      txd_q    <= 8'h00;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      txd_q    <= txd_d;
      vld_q    <= vld_d;
    end
  end

  // Echo storage; entry validity is carried by the count, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_q[wr_ptr_q] <= rx_data;
    end
  end

  assign tx_data     = txd_q;
  assign tx_data_vld = vld_q;
  assign echo_ovf    = ovf_q;
  assign busy        = (state_q != S_IDLE) | ~w_empty | pend_q;

endmodule
`default_nettype wire
